mem_access_seq: RTL
===================

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-003: opcode  input  lc3b_opcode(4)  opcode of the instruction currently in the MEM stage.
REQ-004: mem_read_in  input  1  control-word mem_read of the MEM-stage instruction.
REQ-005: mem_write_in  input  1  control-word mem_write of the MEM-stage instruction.
REQ-006: writemux_sel  input  1  control-word byte-store select; 1 = STB.
REQ-007: addr_in  input  16  effective address from EX/MEM.
REQ-008: wdata_in  input  16  store data from EX/MEM.
REQ-009: dmem_resp  input  1  data-memory completion pulse for the current request.
REQ-010: dmem_rdata  input  16  data-memory read data, valid when dmem_resp=1.
REQ-011: dmem_read  output  1  data-memory read request.
REQ-012: dmem_write  output  1  data-memory write request.
REQ-013: dmem_address  output  16  data-memory address.
REQ-014: dmem_wdata  output  16  data-memory write data.
REQ-015: dmem_byte_enable  output  2  write byte lanes; [0] = low byte, [1] = high byte.
REQ-016: rdata_out  output  16  registered final read data for the WB path.
REQ-017: load_pipe  output  1  1 = pipeline advances; drives load_pc, load_IF_ID, load_ID_EX, load_EX_MEM and load_MEM_WB; 0 = stall.

Function
REQ-018: The FSM SHALL have five states: IDLE, ACC1, ACC2_RD, ACC2_WR, DONE.
REQ-019: A request is defined as (mem_read_in | mem_write_in). If both are 1, the access SHALL be a read and mem_write_in is ignored.
REQ-020: IDLE, no request: load_pipe=1; next state IDLE.
REQ-021: IDLE, request: load_pipe=0; next state ACC1.
REQ-022: ACC1: dmem_read=mem_read_in (with read priority) and dmem_write=!mem_read_in & mem_write_in; dmem_address=addr_in; load_pipe=0.
REQ-023: ACC1, dmem_resp=1, opcode=op_ldi: latch dmem_rdata into ptr_reg; next state ACC2_RD.
REQ-024: ACC1, dmem_resp=1, opcode=op_sti: latch dmem_rdata into ptr_reg; next state ACC2_WR.
REQ-025: ACC1, dmem_resp=1, any other opcode: latch dmem_rdata into rdata_out on reads, leave it unchanged on writes; next state DONE.
REQ-026: ACC2_RD: dmem_read=1; dmem_address=ptr_reg; on dmem_resp, latch dmem_rdata into rdata_out; next state DONE.
REQ-027: ACC2_WR: dmem_write=1; dmem_address=ptr_reg; dmem_wdata=wdata_in; dmem_byte_enable=2'b11; on dmem_resp, next state DONE.
REQ-028: In any ACC state with dmem_resp=0, the FSM SHALL hold its state, and all request outputs SHALL stay constant (no wait-state limit).
REQ-029: DONE: load_pipe=1 for exactly one cycle; no dmem request; next state IDLE, which then evaluates the newly latched instruction.
REQ-030: Word write (writemux_sel=0): dmem_wdata=wdata_in; dmem_byte_enable=2'b11.
REQ-031: Byte write (writemux_sel=1): dmem_wdata={wdata_in[7:0], wdata_in[7:0]}; dmem_byte_enable=2'b01 when addr_in[0]=0, 2'b10 when addr_in[0]=1.
REQ-032: dmem_byte_enable SHALL be 2'b00 whenever dmem_write=0.
REQ-033: Byte extraction for LDB is outside this block; rdata_out always carries the full word.
REQ-034: dmem_resp SHALL be ignored in IDLE and DONE.
REQ-035: Stall latency with zero-wait memory (counted from instruction arrival to the load_pipe=1 cycle): 2 stall cycles for single-access ops; 3 stall cycles for LDI and STI.
REQ-036: load_pipe, dmem_read and dmem_write SHALL be decoded from state (Moore outputs), plus the IDLE request check in REQ-020/REQ-021.

Reset
REQ-037: On reset: state=IDLE, ptr_reg=0, rdata_out=0.
REQ-038: While reset is asserted: dmem_read=0, dmem_write=0, dmem_byte_enable=2'b00, load_pipe=1.
REQ-039: Reset asserted mid-access SHALL abandon the access immediately; a dmem_resp arriving after reset deassertion SHALL be ignored.

Verification
REQ-040: LDR, addr_in=0x1000, memory returns 0xBEEF on the 1st ACC1 cycle -> load_pipe sequence 0,0,1; rdata_out=0xBEEF in DONE.
REQ-041: LDI, addr_in=0x2000, mem[0x2000]=0x3000, mem[0x3000]=0x1234 -> dmem_address 0x2000 then 0x3000; rdata_out=0x1234; 3 stall cycles.
REQ-042: STI, addr_in=0x2000 holding 0x4000, wdata_in=0x5A5A -> read at 0x2000, then write at 0x4000 with data 0x5A5A and byte_enable 2'b11.
REQ-043: STB, addr_in=0x0101, wdata_in=0x00AB -> dmem_wdata=0xABAB, dmem_byte_enable=2'b10.
REQ-044: LDR with 5 wait cycles, reset asserted on wait cycle 3 -> dmem_read drops asynchronously; state=IDLE; a late dmem_resp does not change rdata_out (stays 0).
REQ-045: ADD back-to-back with STR (both mem_read_in=1 and mem_write_in=1 forced) -> ADD gives load_pipe=1 with no request; STR issues a read only (read priority).

Source files
------------

// File: rtl/mem_access_seq.sv
// MEM-stage data-memory sequencer: single accesses plus the two-access LDI/STI
// pointer chase, stalling the pipeline until the memory completes.
module mem_access_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        writemux_sel,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] rdata_out,
    output logic        load_pipe
);

    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC1    = 3'd1,
        ACC2_RD = 3'd2,
        ACC2_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] ptr_r;
    logic        req_s;
    logic        acc1_write_s;

    assign req_s        = mem_read_in | mem_write_in;
    assign acc1_write_s = ~mem_read_in & mem_write_in;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; dmem_resp only matters in the access states.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    next_state_s = ACC1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACC1: begin
                if (!dmem_resp) begin
                    next_state_s = ACC1;
                end else if (opcode == OP_LDI) begin
                    next_state_s = ACC2_RD;
                end else if (opcode == OP_STI) begin
                    next_state_s = ACC2_WR;
                end else begin
                    next_state_s = DONE;
                end
            end
            ACC2_RD, ACC2_WR: begin
                if (dmem_resp) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Memory request and stall decode; reset forces a quiet bus and a free pipeline.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = addr_in;
        dmem_wdata       = wdata_in;
        dmem_byte_enable = 2'b00;
        load_pipe        = 1'b0;
        case (state_r)
            IDLE: load_pipe = ~req_s;
            ACC1: begin
                dmem_read  = mem_read_in;
                dmem_write = acc1_write_s;
                if (acc1_write_s && writemux_sel) begin
                    dmem_wdata       = {wdata_in[7:0], wdata_in[7:0]};
                    dmem_byte_enable = addr_in[0] ? 2'b10 : 2'b01;
                end else if (acc1_write_s) begin
                    dmem_byte_enable = 2'b11;
                end else begin
                    dmem_byte_enable = 2'b00;
                end
            end
            ACC2_RD: begin
                dmem_read    = 1'b1;
                dmem_address = ptr_r;
            end
            ACC2_WR: begin
                dmem_write       = 1'b1;
                dmem_address     = ptr_r;
                dmem_byte_enable = 2'b11;
            end
            DONE:    load_pipe = 1'b1;
            default: load_pipe = 1'b1;
        endcase
        if (reset) begin
            dmem_read        = 1'b0;
            dmem_write       = 1'b0;
            dmem_byte_enable = 2'b00;
            load_pipe        = 1'b1;
        end else begin
            load_pipe = load_pipe;
        end
    end

    // Pointer and read-data capture on each completed access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r     <= 16'h0000;
            rdata_out <= 16'h0000;
        end else if (state_r == ACC1 && dmem_resp) begin
            if (opcode == OP_LDI || opcode == OP_STI) begin
                ptr_r <= dmem_rdata;
            end else if (mem_read_in) begin
                rdata_out <= dmem_rdata;
            end else begin
                rdata_out <= rdata_out;
            end
        end else if (state_r == ACC2_RD && dmem_resp) begin
            rdata_out <= dmem_rdata;
        end else begin
            ptr_r     <= ptr_r;
            rdata_out <= rdata_out;
        end
    end

endmodule
